// File: rtl/instruction_loader_pkg.sv
// Shared constants and state encoding for the program-load sequencer.
package instruction_loader_pkg;

  localparam int unsigned BITS_FOR_STATE_COUNTER_INSTRUCTION_LOADER = 3;

  localparam int unsigned DEFAULT_BYTE_SIZE          = 8;
  localparam int unsigned DEFAULT_WORD_SIZE_IN_BYTES = 4;
  localparam int unsigned DEFAULT_MEM_SIZE_IN_WORDS  = 64;

  // Terminates a program image; instruction_memory recognises the same value.
  localparam logic [31:0] INSTRUCTION_HALT = 32'hFFFF_FFFF;

  localparam logic        LOW   = 1'b0;
  localparam logic        HIGH  = 1'b1;
  localparam int unsigned CLEAR = 0;

  typedef enum logic [BITS_FOR_STATE_COUNTER_INSTRUCTION_LOADER-1:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StCollect = 3'd2,
    StWrite   = 3'd3,
    StGap     = 3'd4,
    StDone    = 3'd5,
    StError   = 3'd6
  } state_e;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Little-endian byte-to-word shift-in register with a byte position counter.
module instruction_loader_byte_assembler #(
  parameter int unsigned WORD_SIZE_IN_BYTES = 4,
  parameter int unsigned BYTE_SIZE          = 8,
  localparam int unsigned WordWidth = WORD_SIZE_IN_BYTES * BYTE_SIZE,
  localparam int unsigned CntWidth  =
      (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 accept_i,
  input  logic                 clear_i,
  input  logic [BYTE_SIZE-1:0] byte_i,
  output logic                 word_ready_o,
  output logic [WordWidth-1:0] word_o
);

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(WORD_SIZE_IN_BYTES - 1);

  logic [WordWidth-1:0] word_q, word_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 last_byte;

  assign last_byte    = (cnt_q == LastCnt);
  assign word_ready_o = accept_i && last_byte;

  // word_o already carries the byte being accepted, so the final word is
  // available in the same cycle the last byte arrives.
  always_comb begin
    word_o = word_q;
    word_o[cnt_q * BYTE_SIZE +: BYTE_SIZE] = byte_i;
  end

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (accept_i) begin
      word_d = word_o;
      cnt_d  = last_byte ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Program-load sequencer: UART bytes -> little-endian words -> gapped memory write strobes.
module instruction_loader #(
  parameter int unsigned WORD_SIZE_IN_BYTES = instruction_loader_pkg::DEFAULT_WORD_SIZE_IN_BYTES,
  parameter int unsigned MEM_SIZE_IN_WORDS  = instruction_loader_pkg::DEFAULT_MEM_SIZE_IN_WORDS,
  parameter int unsigned BYTE_SIZE          = instruction_loader_pkg::DEFAULT_BYTE_SIZE,
  localparam int unsigned InstrWidth = WORD_SIZE_IN_BYTES * BYTE_SIZE,
  localparam int unsigned CountWidth = $clog2(MEM_SIZE_IN_WORDS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_byte_valid,
  input  logic [BYTE_SIZE-1:0]  i_byte,
  output logic                  o_byte_ready,
  input  logic                  i_mem_full,
  output logic                  o_mem_clear,
  output logic                  o_instruction_write,
  output logic [InstrWidth-1:0] o_instruction,
  output logic                  o_loading,
  output logic                  o_done,
  output logic                  o_error,
  output logic [CountWidth-1:0] o_word_count
);

  import instruction_loader_pkg::*;

  localparam logic [CountWidth-1:0] MemWords = CountWidth'(MEM_SIZE_IN_WORDS);
  localparam logic [InstrWidth-1:0] HaltWord = InstrWidth'(INSTRUCTION_HALT);

  state_e                state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [InstrWidth-1:0] instr_q, instr_d;

  logic                  asm_accept;
  logic                  asm_clear;
  logic                  asm_word_ready;
  logic [InstrWidth-1:0] asm_word;

  // An abort also flushes any partially assembled word.
  assign asm_accept = (state_q == StCollect) && i_byte_valid && !i_abort;
  assign asm_clear  = (state_q == StClear) || i_abort;

  instruction_loader_byte_assembler #(
    .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES),
    .BYTE_SIZE         (BYTE_SIZE)
  ) u_byte_assembler (
    .clk_i       (i_clk),
    .rst_ni      (i_reset),
    .accept_i    (asm_accept),
    .clear_i     (asm_clear),
    .byte_i      (i_byte),
    .word_ready_o(asm_word_ready),
    .word_o      (asm_word)
  );

  always_comb begin
    state_d             = state_q;
    count_d             = count_q;
    instr_d             = instr_q;
    o_byte_ready        = 1'b0;
    o_mem_clear         = 1'b0;
    o_instruction_write = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (i_start) state_d = StClear;
      end
      StClear: begin
        o_mem_clear = 1'b1;
        count_d     = '0;
        instr_d     = '0;
        state_d     = StCollect;
      end
      StCollect: begin
        o_byte_ready = 1'b1;
        if (asm_word_ready) begin
          instr_d = asm_word;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (count_q != MemWords) count_d = count_q + 1'b1;
        if (i_mem_full) begin
          state_d = StError;
        end else begin
          o_instruction_write = 1'b1;
          state_d             = StGap;
        end
      end
      StGap: begin
        if (instr_q == HaltWord) begin
          state_d = StDone;
        end else if (count_q == MemWords) begin
          state_d = StError;
        end else begin
          state_d = StCollect;
        end
      end
      default: state_d = StIdle;
    endcase

    if (i_abort) begin
      state_d             = StIdle;
      count_d             = count_q;
      o_instruction_write = 1'b0;
    end
  end

  assign o_instruction = instr_q;
  assign o_word_count  = count_q;
  assign o_loading     = (state_q == StClear) || (state_q == StCollect) ||
                         (state_q == StWrite) || (state_q == StGap);
  assign o_done        = (state_q == StDone);
  assign o_error       = (state_q == StError);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= StIdle;
      count_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      instr_q <= instr_d;
    end
  end

endmodule
